// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl
// Iteration sequencer for a folded CORDIC datapath. One (x, y) vector is
// accepted, then ITER micro-rotations are run through one external pair of
// rotation stages. The x-stage is the master: its rot_exec flag decides
// whether a rotation is applied, and the y-stage follows that decision.
// The final vector and a per-iteration rotation mask are returned.
//
// Ports
//   clock, rst_n             : clock (rising edge), async active-low reset
//   in_valid/in_ready        : input handshake, in_x/in_y input vector
//   rot_x_din/rot_x_delta    : x-stage operand and shifted addend
//   rot_y_din/rot_y_delta    : y-stage operand and shifted addend
//   rot_dir_x/rot_dir_y      : stage direction, 0 = add, 1 = subtract
//   rot_exec                 : master "rotation applied", one cycle before dout
//   rot_x_dout/rot_y_dout    : stage results
//   out_valid/out_ready      : output handshake, out_x/out_y/out_mask result
//   busy                     : high while RUN or DONE
//   o_dbg_state              : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and holds, with stable data, until out_ready is seen.
module cordic_iter_ctrl #(
  parameter int DSIZE   = 16,
  parameter int ITER    = 12,
  parameter int ROT_LAT = 3
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DSIZE-1:0] in_x,
  input  logic signed [DSIZE-1:0] in_y,
  output logic signed [DSIZE-1:0] rot_x_din,
  output logic signed [DSIZE-1:0] rot_x_delta,
  output logic signed [DSIZE-1:0] rot_y_din,
  output logic signed [DSIZE-1:0] rot_y_delta,
  output logic                    rot_dir_x,
  output logic                    rot_dir_y,
  input  logic                    rot_exec,
  input  logic signed [DSIZE-1:0] rot_x_dout,
  input  logic signed [DSIZE-1:0] rot_y_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DSIZE-1:0] out_x,
  output logic signed [DSIZE-1:0] out_y,
  output logic [ITER-1:0]         out_mask,
  output logic                    busy,
  output logic [1:0]              o_dbg_state
);

  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int KW = $clog2(ROT_LAT + 1);
  localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);
  localparam logic [KW-1:0] K_EXEC = KW'(ROT_LAT - 1);
  localparam logic [KW-1:0] K_CAP  = KW'(ROT_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [IW-1:0]           r_i;
  logic [KW-1:0]           r_k;
  logic signed [DSIZE-1:0] r_x;
  logic signed [DSIZE-1:0] r_y;
  logic [ITER-1:0]         r_mask;
  logic signed [DSIZE-1:0] r_x_din;
  logic signed [DSIZE-1:0] r_x_delta;
  logic signed [DSIZE-1:0] r_y_din;
  logic signed [DSIZE-1:0] r_y_delta;
  logic                    r_dir_x;
  logic                    r_dir_y;

  logic                    w_accept;
  logic                    w_cap;
  logic                    w_load;
  logic signed [DSIZE-1:0] w_src_x;
  logic signed [DSIZE-1:0] w_src_y;
  logic [IW-1:0]           w_sh;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_cap    = (r_state == S_RUN) && (r_k == K_CAP);
  // Stage operands are (re)loaded on accept and on every capture except the
  // last one, so the next iteration starts without a bubble.
  assign w_load   = w_accept || (w_cap && (r_i != LAST_I));

  // Source of the next stage operands: the input vector on accept, otherwise
  // the stage results being captured on this very edge.
  always_comb begin
    w_src_x = rot_x_dout;
    w_src_y = rot_y_dout;
    w_sh    = r_i + 1'b1;
    if (w_accept) begin
      w_src_x = in_x;
      w_src_y = in_y;
      w_sh    = '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (in_valid)                  w_next_state = S_RUN;
      S_RUN:  if (w_cap && (r_i == LAST_I)) w_next_state = S_DONE;
      S_DONE: if (out_ready)                 w_next_state = S_IDLE;
      default:                               w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_i       <= '0;
      r_k       <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_mask    <= '0;
      r_x_din   <= '0;
      r_x_delta <= '0;
      r_y_din   <= '0;
      r_y_delta <= '0;
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x    <= in_x;
        r_y    <= in_y;
        r_i    <= '0;
        r_k    <= '0;
        r_mask <= '0;
      end else if (r_state == S_RUN) begin
        if (r_k == K_EXEC) r_mask[r_i] <= rot_exec;
        if (w_cap) begin
          r_x <= rot_x_dout;
          r_y <= rot_y_dout;
          r_k <= '0;
          if (r_i != LAST_I) r_i <= r_i + 1'b1;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
      if (w_load) begin
        r_x_din   <= w_src_x;
        r_y_din   <= w_src_y;
        r_x_delta <= w_src_y >>> w_sh;
        r_y_delta <= w_src_x >>> w_sh;
        // Rotate towards y = 0: subtract on x when y is negative.
        r_dir_x   <= w_src_y[DSIZE-1];
        r_dir_y   <= ~w_src_y[DSIZE-1];
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign out_x       = r_x;
  assign out_y       = r_y;
  assign out_mask    = r_mask;
  assign rot_x_din   = r_x_din;
  assign rot_x_delta = r_x_delta;
  assign rot_y_din   = r_y_din;
  assign rot_y_delta = r_y_delta;
  assign rot_dir_x   = r_dir_x;
  assign rot_dir_y   = r_dir_y;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Testbench for cordic_iter_ctrl: randomized vectors, a rule-level model of
// the micro-rotation sequence, a stage model that only presents valid
// results in the cycle they are due, and a final report line.
module tb_cordic_iter_ctrl;

  localparam int DW   = 16;
  localparam int IT   = 4;
  localparam int RL   = 3;
  localparam int NCYC = IT * (RL + 1);
  localparam int QW   = IT + 2 * DW;

  logic                 clock;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_x, in_y;
  logic signed [DW-1:0] rot_x_din, rot_x_delta, rot_y_din, rot_y_delta;
  logic                 rot_dir_x, rot_dir_y;
  logic                 rot_exec;
  logic signed [DW-1:0] rot_x_dout, rot_y_dout;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_x, out_y;
  logic [IT-1:0]        out_mask;
  logic                 busy;
  logic [1:0]           dbg_state;

  int n_checks;
  int n_fail;

  logic [QW-1:0]        exp_q[$];
  logic signed [DW-1:0] op_x[IT], op_y[IT], op_dx[IT], op_dy[IT];
  logic                 op_dirx[IT], op_diry[IT];
  logic [IT-1:0]        exec_bits;
  logic signed [DW-1:0] last_dx, last_dy;
  bit                   ab;

  cordic_iter_ctrl #(.DSIZE(DW), .ITER(IT), .ROT_LAT(RL)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .rot_x_din   (rot_x_din),
    .rot_x_delta (rot_x_delta),
    .rot_y_din   (rot_y_din),
    .rot_y_delta (rot_y_delta),
    .rot_dir_x   (rot_dir_x),
    .rot_dir_y   (rot_dir_y),
    .rot_exec    (rot_exec),
    .rot_x_dout  (rot_x_dout),
    .rot_y_dout  (rot_y_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_mask    (out_mask),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_in_ready"},  in_ready, 1);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_busy"},      busy, 0);
    check_val({tag, "_x_din"},     $unsigned(rot_x_din), 0);
    check_val({tag, "_x_delta"},   $unsigned(rot_x_delta), 0);
    check_val({tag, "_y_din"},     $unsigned(rot_y_din), 0);
    check_val({tag, "_y_delta"},   $unsigned(rot_y_delta), 0);
    check_val({tag, "_dir_x"},     rot_dir_x, 0);
    check_val({tag, "_dir_y"},     rot_dir_y, 0);
    check_val({tag, "_out_x"},     $unsigned(out_x), 0);
    check_val({tag, "_out_y"},     $unsigned(out_y), 0);
    check_val({tag, "_out_mask"},  out_mask, 0);
  endtask

  // Reference model: walk the CORDIC rules iteration by iteration.
  // mode 0 = stage never rotates, 1 = always, 2 = random decisions.
  task automatic build_model(input logic signed [DW-1:0] vx, input logic signed [DW-1:0] vy,
                             input int mode);
    logic signed [DW-1:0] mx, my, nx, ny;
    mx = vx;
    my = vy;
    for (int i = 0; i < IT; i++) begin
      exec_bits[i] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      op_x[i]    = mx;
      op_y[i]    = my;
      op_dx[i]   = my >>> i;
      op_dy[i]   = mx >>> i;
      op_dirx[i] = (my < 0);
      op_diry[i] = !(my < 0);
      nx = mx;
      ny = my;
      if (exec_bits[i]) begin
        if (my < 0) begin
          nx = mx - op_dx[i];
          ny = my + op_dy[i];
        end else begin
          nx = mx + op_dx[i];
          ny = my - op_dy[i];
        end
      end
      mx = nx;
      my = ny;
    end
    exp_q.push_back({exec_bits, mx, my});
  endtask

  // Driver: offer one vector, act as the rotation stages, check the operands
  // and the result timing. abort_at >= 0 asserts reset mid-run at that cycle.
  task automatic do_vector(input logic signed [DW-1:0] vx, input logic signed [DW-1:0] vy,
                           input int mode, input int abort_at, output bit aborted);
    int k;
    int i;
    logic [QW-1:0] e;
    aborted = 1'b0;
    build_model(vx, vy, mode);
    @(negedge clock);
    check_val("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_x     = vx;
    in_y     = vy;
    @(posedge clock);
    #1;
    for (int c = 0; c < NCYC; c++) begin
      k = c % (RL + 1);
      i = c / (RL + 1);
      if (c == abort_at) begin
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("rst_run");
        void'(exp_q.pop_back());
        @(negedge clock);
        rst_n   = 1'b1;
        aborted = 1'b1;
        return;
      end
      // Inputs offered during RUN must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      in_x     = DW'($urandom);
      in_y     = DW'($urandom);
      check_val("run_busy",      busy, 1);
      check_val("run_in_ready",  in_ready, 0);
      check_val("run_out_valid", out_valid, 0);
      if (k == 0) begin
        check_val($sformatf("it%0d_x_din", i),   $unsigned(rot_x_din),   $unsigned(op_x[i]));
        check_val($sformatf("it%0d_y_din", i),   $unsigned(rot_y_din),   $unsigned(op_y[i]));
        check_val($sformatf("it%0d_x_delta", i), $unsigned(rot_x_delta), $unsigned(op_dx[i]));
        check_val($sformatf("it%0d_y_delta", i), $unsigned(rot_y_delta), $unsigned(op_dy[i]));
        check_val($sformatf("it%0d_dir_x", i),   rot_dir_x, op_dirx[i]);
        check_val($sformatf("it%0d_dir_y", i),   rot_dir_y, op_diry[i]);
        if (i == IT - 1) begin
          last_dx = rot_x_delta;
          last_dy = rot_y_delta;
        end
      end
      // Stage model: flag and results are only meaningful in their due cycle.
      rot_exec   = (k == RL - 1) ? exec_bits[i] : 1'($urandom_range(0, 1));
      rot_x_dout = DW'($urandom);
      rot_y_dout = DW'($urandom);
      if (k == RL) begin
        rot_x_dout = rot_x_din;
        rot_y_dout = rot_y_din;
        if (exec_bits[i]) begin
          rot_x_dout = rot_dir_x ? rot_x_din - rot_x_delta : rot_x_din + rot_x_delta;
          rot_y_dout = rot_dir_y ? rot_y_din - rot_y_delta : rot_y_din + rot_y_delta;
        end
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    e = exp_q[0];
    check_val("done_out_valid", out_valid, 1);
    check_val("done_busy",      busy, 1);
    check_val("done_in_ready",  in_ready, 0);
    check_val("done_out_x",     $unsigned(out_x), e[2*DW-1:DW]);
    check_val("done_out_y",     $unsigned(out_y), e[DW-1:0]);
    check_val("done_out_mask",  out_mask, e[QW-1:2*DW]);
  endtask

  // Output side: hold off for 'hold' cycles (optionally poking in_valid),
  // then accept and check the return to IDLE.
  task automatic accept_out(input int hold, input bit poke);
    logic [QW-1:0] e;
    e = exp_q[0];
    for (int c = 0; c < hold; c++) begin
      @(negedge clock);
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_in_ready",  in_ready, 0);
      check_val("hold_out_x",     $unsigned(out_x), e[2*DW-1:DW]);
      check_val("hold_out_y",     $unsigned(out_y), e[DW-1:0]);
      check_val("hold_out_mask",  out_mask, e[QW-1:2*DW]);
      in_valid = poke && (c == 3);
      in_x     = DW'($urandom);
      in_y     = DW'($urandom);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_val("ack_out_valid", out_valid, 0);
    check_val("ack_in_ready",  in_ready, 1);
    check_val("ack_busy",      busy, 0);
    void'(exp_q.pop_front());
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    out_ready  = 1'b0;
    rot_exec   = 1'b0;
    rot_x_dout = '0;
    rot_y_dout = '0;
    last_dx    = '0;
    last_dy    = '0;

    #12 rst_n = 1'b0;
    #1 check_reset("por");
    @(negedge clock);
    rst_n = 1'b1;

    // Worked vector, stage always rotating, then never rotating.
    do_vector(16'sd1000, 16'sd0, 1, -1, ab);
    accept_out(2, 1'b0);
    do_vector(16'sd1000, 16'sd0, 0, -1, ab);
    check_val("norot_out_x", $unsigned(out_x), 1000);
    check_val("norot_out_y", $unsigned(out_y), 0);
    accept_out(0, 1'b0);

    // Sign fill of the last-iteration shifts.
    do_vector(-16'sd1, -16'sd8, 0, -1, ab);
    check_val("signfill_y_delta", $unsigned(last_dy), 16'hFFFF);
    check_val("signfill_x_delta", $unsigned(last_dx), 16'hFFFF);
    accept_out(1, 1'b0);

    // Backpressure with an ignored new vector.
    do_vector(DW'($urandom), DW'($urandom), 2, -1, ab);
    accept_out(10, 1'b1);

    // Reset in RUN at iteration 1, k = 2, then a fresh vector.
    do_vector(DW'($urandom), DW'($urandom), 1, 1 * (RL + 1) + 2, ab);
    check_val("abort_taken", ab, 1);
    do_vector(DW'($urandom), DW'($urandom), 2, -1, ab);
    accept_out(0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      do_vector(DW'($urandom), DW'($urandom), 2, -1, ab);
      accept_out($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
